// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and default frame/oversampling settings
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_NB_DATA    = 8;
    localparam int DEF_SB_TICK    = 16;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver-side bus; o_parity_err exists only with UART_RX_PARITY_EN
interface uart_rx_if #(parameter int NB_DATA = 8);
    logic               i_tick;
    logic               i_rx;
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done;
    logic               o_frame_err;
    logic               o_busy;
`ifdef UART_RX_PARITY_EN
    logic               o_parity_err;
    modport master (input i_tick, i_rx, output o_data, o_rx_done, o_frame_err, o_busy, o_parity_err);
    modport slave (output i_tick, i_rx, input o_data, o_rx_done, o_frame_err, o_busy, o_parity_err);
`else
    modport master (input i_tick, i_rx, output o_data, o_rx_done, o_frame_err, o_busy);
    modport slave (output i_tick, i_rx, input o_data, o_rx_done, o_frame_err, o_busy);
`endif
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous, idle-high serial line
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_sync;
    // shift the line through two flops; reset to the idle level
    always_ff @(posedge i_clk)
        if (i_reset) r_sync <= 2'b11;
        else r_sync <= {r_sync[0], i_d};
    assign o_q = r_sync[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver; parity stage enabled by UART_RX_PARITY_EN
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA    = DEF_NB_DATA,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input logic       i_clk,
    input logic       i_reset,
    uart_rx_if.master bus
);
    localparam int NB_TICK = $clog2(SB_TICK > OVERSAMPLE ? SB_TICK : OVERSAMPLE);
    localparam int NB_BIT  = $clog2(NB_DATA);
    localparam logic [NB_TICK-1:0] TICK_MID  = NB_TICK'(OVERSAMPLE / 2 - 1);
    localparam logic [NB_TICK-1:0] TICK_BIT  = NB_TICK'(OVERSAMPLE - 1);
    localparam logic [NB_TICK-1:0] TICK_STOP = NB_TICK'(SB_TICK - 1);
    localparam logic [NB_BIT-1:0]  BIT_LAST  = NB_BIT'(NB_DATA - 1);
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t             r_state;
    logic [NB_TICK-1:0] r_tick;
    logic [NB_BIT-1:0]  r_bit;
    logic [NB_DATA-1:0] r_shift;
    logic [NB_DATA-1:0] r_data;
    logic               r_done;
    logic               r_ferr;
    logic               r_busy;
    logic               w_rx_s;
`ifdef UART_RX_PARITY_EN
    logic               r_par;
    logic               r_perr;
`endif

    uart_rx_sync u_sync (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_d    (bus.i_rx),
        .o_q    (w_rx_s)
    );

    // frame FSM: start detect, mid-bit sampling, stop check and registered strobes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr <= 1'b0;
`endif
            case (r_state)
                IDLE:
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_tick  <= '0;
                        r_busy  <= 1'b1;
                    end
                START:
                    if (bus.i_tick) begin
                        if (r_tick == TICK_MID) begin
                            r_state <= w_rx_s ? IDLE : DATA;
                            r_busy  <= !w_rx_s;
                            r_tick  <= '0;
                            r_bit   <= '0;
                        end else r_tick <= r_tick + 1'b1;
                    end
                DATA:
                    if (bus.i_tick) begin
                        if (r_tick == TICK_BIT) begin
                            r_shift <= {w_rx_s, r_shift[NB_DATA-1:1]};
                            r_tick  <= '0;
                            r_bit   <= r_bit + 1'b1;
                            r_state <= (r_bit == BIT_LAST) ? AFTER_DATA : DATA;
                        end else r_tick <= r_tick + 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                PARITY:
                    if (bus.i_tick) begin
                        if (r_tick == TICK_BIT) begin
                            r_par   <= w_rx_s;
                            r_tick  <= '0;
                            r_state <= STOP;
                        end else r_tick <= r_tick + 1'b1;
                    end
`endif
                STOP:
                    if (bus.i_tick) begin
                        if (r_tick == TICK_STOP) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_data  <= r_shift;
                            r_done  <= w_rx_s;
                            r_ferr  <= !w_rx_s;
`ifdef UART_RX_PARITY_EN
                            r_perr  <= (^{r_shift, r_par}) != PARITY_ODD;
`endif
                        end else r_tick <= r_tick + 1'b1;
                    end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_data      = r_data;
    assign bus.o_rx_done   = r_done;
    assign bus.o_frame_err = r_ferr;
    assign bus.o_busy      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_err = r_perr;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames checked against a frame-level expectation queue
module tb_uart_rx;
    localparam int BIT_CLKS = 64;

    typedef struct {
        logic [7:0] d;
        logic       done;
        logic       ferr;
        logic       perr;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_seen = 1'b1;
    logic [1:0] tcnt = 2'd0;
    logic [7:0] m_data = 8'h00;
    logic       prev_busy = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         n_done = 0;
    int         n_ferr = 0;
    ev_t        q[$];

    uart_rx_if #(.NB_DATA(8)) bus ();

    uart_rx dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tcnt     <= tcnt + 2'd1;
        rst_seen <= rst;
    end
    assign bus.i_tick = (tcnt == 2'd3);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic b, input int n);
        bus.i_rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic p);
        ev_t e;
        e.d    = d;
        e.done = stop_ok;
        e.ferr = !stop_ok;
`ifdef UART_RX_PARITY_EN
        e.perr = ^{d, p};
`else
        e.perr = 1'b0;
        if (p) e.perr = 1'b0;
`endif
        q.push_back(e);
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        drive(p, BIT_CLKS);
`endif
        if (stop_ok) drive(1'b1, BIT_CLKS);
        else drive(1'b0, 48);
    endtask

    always @(negedge clk) begin
        if (rst_seen) begin
            q.delete();
            m_data = 8'h00;
            chk("reset_data", {24'd0, bus.o_data}, 32'h0);
            chk("reset_strobes", {30'd0, bus.o_rx_done, bus.o_frame_err}, 32'h0);
            chk("reset_busy", {31'd0, bus.o_busy}, 32'h0);
        end else begin
            if (bus.o_rx_done || bus.o_frame_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, bus.o_rx_done, bus.o_frame_err}, 32'h0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    m_data = e.d;
                    chk("strobe_done", {31'd0, bus.o_rx_done}, {31'd0, e.done});
                    chk("strobe_ferr", {31'd0, bus.o_frame_err}, {31'd0, e.ferr});
`ifdef UART_RX_PARITY_EN
                    chk("strobe_perr", {31'd0, bus.o_parity_err}, {31'd0, e.perr});
`endif
                    chk("busy_falls", {30'd0, prev_busy, bus.o_busy}, 32'h2);
                end
                if (bus.o_rx_done) n_done++;
                if (bus.o_frame_err) n_ferr++;
            end
            chk("data_hold", {24'd0, bus.o_data}, {24'd0, m_data});
        end
        prev_busy = bus.o_busy;
    end

    initial begin
        bus.i_rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 100);

        send_frame(8'h55, 1'b1, 1'b0);
        drive(1'b1, 100);
        chk("lit_55", {24'd0, bus.o_data}, 32'h55);
        chk("lit_done1", n_done, 1);

        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b1);
        drive(1'b1, 100);
        chk("lit_0f", {24'd0, bus.o_data}, 32'h0F);
        chk("lit_done3", n_done, 3);

        drive(1'b0, 12);
        drive(1'b1, 150);
        chk("lit_glitch", {24'd0, bus.o_data}, 32'h0F);
        chk("lit_glitch_busy", {31'd0, bus.o_busy}, 32'h0);

        send_frame(8'h3C, 1'b0, 1'b0);
        drive(1'b1, 200);
        chk("lit_3c", {24'd0, bus.o_data}, 32'h3C);
        chk("lit_ferr1", n_ferr, 1);
        chk("lit_done_still3", n_done, 3);

        drive(1'b0, BIT_CLKS);
        drive(1'b1, 4 * BIT_CLKS + 32);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 200);
        chk("lit_after_reset", {24'd0, bus.o_data}, 32'h0);
        chk("lit_no_abort_strobe", n_done, 3);

        send_frame(8'h81, 1'b1, 1'b0);
        drive(1'b1, 100);
        chk("lit_81", {24'd0, bus.o_data}, 32'h81);
        chk("lit_done4", n_done, 4);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        drive(1'b1, 100);
        send_frame(8'h07, 1'b1, 1'b0);
        drive(1'b1, 100);
        chk("lit_par_done", n_done, 6);
`endif

        drive(1'b1, 200);
        chk("pending_frames", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
